sistema_ram_arbiter: RTL and testbench

- Two-master round-robin arbiter that shares the single-port on-chip RAM (32-bit words, 12-bit word address, byteenable, one-cycle read latency) between the CPU data master and a DMA/peripheral master.
- Sits between the two Avalon-MM masters and the RAM slave port.
- Adds waitrequest back-pressure, per-master readdatavalid routing and out-of-range address protection.

---
 rtl/sistema_ram_arb_pkg.sv | 19 +
 rtl/sistema_ram_arbiter_if.sv | 27 ++
 rtl/sistema_ram_arb_rr.sv | 54 +++++
 rtl/sistema_ram_arbiter.sv | 152 +++++++++++++++
 tb/tb_sistema_ram_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sistema_ram_arb_pkg.sv
// Shared definitions for the two-master RAM arbiter.
// Contents:
//   M0, M1      master-id constants (M1 is the reset value of last_grant)
//   ret_entry_t one entry of the read-return pipeline {valid, id, oor}
//   OOR_DATA    value returned for out-of-range reads
package sistema_ram_arb_pkg;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
        logic oor;
    } ret_entry_t;

    localparam int OOR_DATA = 0;

endpackage

// File: rtl/sistema_ram_arbiter_if.sv
// Avalon-MM master bus as seen between one master and the arbiter.
// master modport: the requester drives the command and receives
//   waitrequest/readdata/readdatavalid.
// slave modport: the arbiter side, the mirror image.
interface sistema_ram_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/sistema_ram_arb_rr.sv
// Two-way round-robin grant unit.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   req0_i, req1_i   requests from master 0 / master 1
//   en_i             commands may be accepted this cycle (low during reset)
//   gnt0_o, gnt1_o   combinational one-hot (or zero) grant
// last_grant resets to M1 so master 0 wins the first tie.
module sistema_ram_arb_rr
    import sistema_ram_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req0_i,
    input  logic req1_i,
    input  logic en_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    logic last_grant_q;
    logic last_grant_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= M1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        gnt0_o       = 1'b0;
        gnt1_o       = 1'b0;
        last_grant_d = last_grant_q;

        if (req0_i && req1_i) begin
            // Tie: serve whoever was not served last.
            if (last_grant_q == M1) begin
                gnt0_o = 1'b1;
            end else begin
                gnt1_o = 1'b1;
            end
        end else if (req0_i) begin
            gnt0_o = 1'b1;
        end else if (req1_i) begin
            gnt1_o = 1'b1;
        end

        if (en_i && (gnt0_o || gnt1_o)) begin
            last_grant_d = gnt1_o ? M1 : M0;
        end
    end

endmodule

// File: rtl/sistema_ram_arbiter.sv
// Round-robin arbiter sharing one single-port on-chip RAM between the CPU
// data master (m0) and a DMA/peripheral master (m1).
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   m0_if, m1_if      Avalon-MM slave side of each master bus
//   ram_*             RAM slave port (address, byteenable, chipselect,
//                     write, writedata, clken out; readdata in)
// Optional build macro SISTEMA_RAM_ARB_ERRCNT_EN adds:
//   oor_count         16-bit saturating count of out-of-range commands
//   oor_last_master   id of the most recent out-of-range offender
// Out-of-range commands (address >= NUM_WORDS) are accepted but never reach
// the RAM; reads among them return OOR_DATA at the normal latency.
module sistema_ram_arbiter
    import sistema_ram_arb_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int NUM_WORDS = 3750,
    parameter int RD_LAT    = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    sistema_ram_arbiter_if.slave m0_if,
    sistema_ram_arbiter_if.slave m1_if,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata
`ifdef SISTEMA_RAM_ARB_ERRCNT_EN
    ,
    output logic [15:0]         oor_count,
    output logic                oor_last_master
`endif
);

    localparam logic [ADDR_W:0] NUM_WORDS_L = (ADDR_W+1)'(NUM_WORDS);

    logic                req0, req1;
    logic                gnt0, gnt1;
    logic                accept;
    logic                sel_id;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W/8-1:0] sel_be;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_write;
    logic                in_range;
    logic [DATA_W-1:0]   ret_data;

    ret_entry_t ret_d;
    ret_entry_t ret_q [RD_LAT];
    ret_entry_t ret_tail;

    assign req0 = m0_if.read | m0_if.write;
    assign req1 = m1_if.read | m1_if.write;

    sistema_ram_arb_rr u_rr (
        .clk    (clk),
        .rst_n  (reset_n),
        .req0_i (req0),
        .req1_i (req1),
        .en_i   (reset_n),
        .gnt0_o (gnt0),
        .gnt1_o (gnt1)
    );

    // waitrequest is purely request/grant based, even while in reset.
    assign m0_if.waitrequest = req0 & ~gnt0;
    assign m1_if.waitrequest = req1 & ~gnt1;

    // Nothing is accepted while reset is held, regardless of grant.
    assign accept = (gnt0 | gnt1) & reset_n;

    assign sel_id    = gnt1 ? M1 : M0;
    assign sel_addr  = gnt1 ? m1_if.address    : m0_if.address;
    assign sel_be    = gnt1 ? m1_if.byteenable : m0_if.byteenable;
    assign sel_wdata = gnt1 ? m1_if.writedata  : m0_if.writedata;
    // A command with both read and write set is treated as a write.
    assign sel_write = gnt1 ? m1_if.write      : m0_if.write;

    assign in_range = ({1'b0, sel_addr} < NUM_WORDS_L);

    assign ram_address    = sel_addr;
    assign ram_byteenable = sel_be;
    assign ram_writedata  = sel_wdata;
    assign ram_chipselect = accept & in_range;
    assign ram_write      = accept & sel_write & in_range;
    assign ram_clken      = reset_n;

    always_comb begin
        ret_d       = '0;
        ret_d.valid = accept & ~sel_write;
        ret_d.id    = sel_id;
        ret_d.oor   = ~in_range;
    end

    // Return pipeline: entry i is i+1 cycles past its accept edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                ret_q[i] <= '0;
            end
        end else begin
            ret_q[0] <= ret_d;
            for (int i = 1; i < RD_LAT; i++) begin
                ret_q[i] <= ret_q[i-1];
            end
        end
    end

    assign ret_tail = ret_q[RD_LAT-1];
    assign ret_data = ret_tail.oor ? DATA_W'(OOR_DATA) : ram_readdata;

    assign m0_if.readdatavalid = ret_tail.valid & (ret_tail.id == M0);
    assign m1_if.readdatavalid = ret_tail.valid & (ret_tail.id == M1);
    assign m0_if.readdata      = m0_if.readdatavalid ? ret_data : '0;
    assign m1_if.readdata      = m1_if.readdatavalid ? ret_data : '0;

`ifdef SISTEMA_RAM_ARB_ERRCNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] oor_count_q, oor_count_d;
    logic        oor_last_q, oor_last_d;

    always_comb begin
        oor_count_d = oor_count_q;
        oor_last_d  = oor_last_q;
        if (accept && !in_range) begin
            oor_count_d = sat_inc16(oor_count_q);
            oor_last_d  = sel_id;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            oor_count_q <= 16'd0;
            oor_last_q  <= 1'b0;
        end else begin
            oor_count_q <= oor_count_d;
            oor_last_q  <= oor_last_d;
        end
    end

    assign oor_count       = oor_count_q;
    assign oor_last_master = oor_last_q;
`endif

endmodule

// File: tb/tb_sistema_ram_arbiter.sv
module tb_sistema_ram_arbiter;

    localparam int RD_LAT = 1;
    localparam int NW     = 3750;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [11:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect;
    logic        ram_write;
    logic [31:0] ram_writedata;
    logic        ram_clken;
    logic [31:0] ram_readdata = 32'd0;
`ifdef SISTEMA_RAM_ARB_ERRCNT_EN
    logic [15:0] oor_count;
    logic        oor_last_master;
`endif

    int checks = 0;
    int failures = 0;

    sistema_ram_arbiter_if #(.ADDR_W(12), .DATA_W(32)) m0_if ();
    sistema_ram_arbiter_if #(.ADDR_W(12), .DATA_W(32)) m1_if ();

    sistema_ram_arbiter #(.ADDR_W(12), .DATA_W(32), .NUM_WORDS(NW), .RD_LAT(RD_LAT)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m0_if          (m0_if),
        .m1_if          (m1_if),
        .ram_address    (ram_address),
        .ram_byteenable (ram_byteenable),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_clken      (ram_clken),
        .ram_readdata   (ram_readdata)
`ifdef SISTEMA_RAM_ARB_ERRCNT_EN
        ,
        .oor_count       (oor_count),
        .oor_last_master (oor_last_master)
`endif
    );

    always #5 clk = ~clk;

    // Environment RAM: one-cycle registered read.
    logic [31:0] mem [0:4095];
    initial for (int i = 0; i < 4096; i++) mem[i] = 32'd0;

    always @(posedge clk) begin
        if (ram_clken && ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            end else begin
                ram_readdata <= mem[ram_address];
            end
        end
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- Behavioural model + per-cycle compare ----------------
    typedef struct {
        int          due;
        bit          id;
        logic [31:0] data;
    } pend_t;

    logic [31:0] ref_mem [0:4095];
    initial for (int i = 0; i < 4096; i++) ref_mem[i] = 32'd0;

    pend_t pq[$];
    bit    mlast = 1'b1;
    int    cyc = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            pq.delete();
            mlast = 1'b1;
            chk1("rst_rdv0", m0_if.readdatavalid, 1'b0);
            chk1("rst_rdv1", m1_if.readdatavalid, 1'b0);
            chk32("rst_rd0", m0_if.readdata, 32'd0);
            chk32("rst_rd1", m1_if.readdata, 32'd0);
            chk1("rst_cs", ram_chipselect, 1'b0);
            chk1("rst_clken", ram_clken, 1'b0);
        end else begin
            bit          ev0, ev1, r0, r1, g0, g1, id, wr, inr;
            logic [31:0] ed0, ed1, wd;
            logic [11:0] addr;
            logic [3:0]  be;
            ev0 = 0; ev1 = 0; ed0 = 0; ed1 = 0;
            if (pq.size() > 0 && pq[0].due == cyc) begin
                if (pq[0].id) begin ev1 = 1; ed1 = pq[0].data; end
                else begin ev0 = 1; ed0 = pq[0].data; end
                void'(pq.pop_front());
            end
            chk1("rdv0", m0_if.readdatavalid, ev0);
            chk1("rdv1", m1_if.readdatavalid, ev1);
            if (ev0) chk32("rdata0", m0_if.readdata, ed0);
            if (ev1) chk32("rdata1", m1_if.readdata, ed1);

            r0 = m0_if.read | m0_if.write;
            r1 = m1_if.read | m1_if.write;
            g0 = r0 && (!r1 || mlast);
            g1 = r1 && !g0;
            chk1("wait0", m0_if.waitrequest, r0 && !g0);
            chk1("wait1", m1_if.waitrequest, r1 && !g1);
            chk1("clken", ram_clken, 1'b1);

            if (g0 || g1) begin
                id   = g1;
                addr = id ? m1_if.address    : m0_if.address;
                be   = id ? m1_if.byteenable : m0_if.byteenable;
                wd   = id ? m1_if.writedata  : m0_if.writedata;
                wr   = id ? m1_if.write      : m0_if.write;
                inr  = (int'(addr) < NW);
                chk1("ram_cs", ram_chipselect, inr);
                chk1("ram_wr", ram_write, wr && inr);
                if (inr) chk32("ram_addr", {20'd0, ram_address}, {20'd0, addr});
                if (wr && inr) begin
                    chk32("ram_wdata", ram_writedata, wd);
                    chk32("ram_be", {28'd0, ram_byteenable}, {28'd0, be});
                    for (int b = 0; b < 4; b++)
                        if (be[b]) ref_mem[addr][8*b +: 8] = wd[8*b +: 8];
                end
                if (!wr) pq.push_back('{due: cyc + RD_LAT, id: id, data: inr ? ref_mem[addr] : 32'd0});
                mlast = id;
            end else begin
                chk1("ram_cs_idle", ram_chipselect, 1'b0);
            end
            cyc++;
        end
    end

    // ---------------- Master drivers ----------------
    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } cmd_t;

    cmd_t q0[$];
    cmd_t q1[$];
    bit   w0_s, w1_s, cs_s, wr_s;

    task automatic drive();
        if (q0.size() > 0) begin
            m0_if.read = !q0[0].wr; m0_if.write = q0[0].wr;
            m0_if.address = q0[0].addr; m0_if.byteenable = q0[0].be; m0_if.writedata = q0[0].data;
        end else begin
            m0_if.read = 0; m0_if.write = 0;
        end
        if (q1.size() > 0) begin
            m1_if.read = !q1[0].wr; m1_if.write = q1[0].wr;
            m1_if.address = q1[0].addr; m1_if.byteenable = q1[0].be; m1_if.writedata = q1[0].data;
        end else begin
            m1_if.read = 0; m1_if.write = 0;
        end
    endtask

    task automatic step();
        bit a0, a1;
        @(negedge clk);
        a0 = (q0.size() > 0) && !m0_if.waitrequest && reset_n;
        a1 = (q1.size() > 0) && !m1_if.waitrequest && reset_n;
        w0_s = m0_if.waitrequest; w1_s = m1_if.waitrequest;
        cs_s = ram_chipselect; wr_s = ram_write;
        @(posedge clk); #1;
        if (a0) void'(q0.pop_front());
        if (a1) void'(q1.pop_front());
        drive();
    endtask

    task automatic run(output int n, output int nwr);
        n = 0; nwr = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < 100) begin
            step();
            n++;
            if (wr_s) nwr++;
        end
        if (n >= 100) chk1("run_timeout", 1'b1, 1'b0);
    endtask

    function automatic cmd_t mk(bit wr, logic [11:0] a, logic [3:0] be, logic [31:0] d);
        cmd_t c;
        c.wr = wr; c.addr = a; c.be = be; c.data = d;
        return c;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, nwr;
        m0_if.read = 0; m0_if.write = 0; m0_if.address = 0; m0_if.byteenable = 0; m0_if.writedata = 0;
        m1_if.read = 0; m1_if.write = 0; m1_if.address = 0; m1_if.byteenable = 0; m1_if.writedata = 0;

        // Reset state
        @(negedge clk);
        chk1("lit_rst_rdv0", m0_if.readdatavalid, 1'b0);
        chk1("lit_rst_clken", ram_clken, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Simultaneous reads from reset: m0 first, then m1
        q0.push_back(mk(0, 12'h005, 4'hF, 0));
        q1.push_back(mk(0, 12'h006, 4'hF, 0));
        drive();
        step();
        chk1("lit_tie_w0", w0_s, 1'b0);
        chk1("lit_tie_w1", w1_s, 1'b1);
        step();
        chk1("lit_tie2_w1", w1_s, 1'b0);
        repeat (3) step();

        // Single master write then read
        q0.push_back(mk(1, 12'h010, 4'hF, 32'hA5A5_1234));
        q0.push_back(mk(0, 12'h010, 4'hF, 0));
        drive();
        step();
        chk1("lit_wr_w0", w0_s, 1'b0);
        step();
        chk1("lit_rd_w0", w0_s, 1'b0);
        @(negedge clk);
        chk1("lit_t1_rdv0", m0_if.readdatavalid, 1'b1);
        chk32("lit_t1_data", m0_if.readdata, 32'hA5A5_1234);
        chk1("lit_t1_rdv1", m1_if.readdatavalid, 1'b0);

        // Sustained contention: 8 writes each
        for (int i = 0; i < 8; i++) begin
            q0.push_back(mk(1, 12'h100 + 12'(i), 4'hF, 32'h1000_0000 + i));
            q1.push_back(mk(1, 12'h200 + 12'(i), 4'hF, 32'h2000_0000 + i));
        end
        @(posedge clk); #1;
        drive();
        run(n, nwr);
        chk32("lit_cont_cycles", n, 16);
        chk32("lit_cont_writes", nwr, 16);
        q0.push_back(mk(0, 12'h103, 4'hF, 0));
        q1.push_back(mk(0, 12'h207, 4'hF, 0));
        drive();
        run(n, nwr);
        repeat (2) step();

        // Byte-lane write
        q0.push_back(mk(1, 12'h020, 4'hF, 32'hFFFF_FFFF));
        q0.push_back(mk(1, 12'h020, 4'h2, 32'h0000_0000));
        q0.push_back(mk(0, 12'h020, 4'hF, 0));
        drive();
        run(n, nwr);
        @(negedge clk);
        chk1("lit_be_rdv0", m0_if.readdatavalid, 1'b1);
        chk32("lit_be_data", m0_if.readdata, 32'hFFFF_00FF);

        // Reset mid-read
        @(posedge clk); #1;
        q0.push_back(mk(0, 12'h010, 4'hF, 0));
        drive();
        step();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 reset_n = 1'b1;
        q0.push_back(mk(0, 12'h020, 4'hF, 0));
        q1.push_back(mk(0, 12'h021, 4'hF, 0));
        drive();
        step();
        chk1("lit_rst_tie_w0", w0_s, 1'b0);
        chk1("lit_rst_tie_w1", w1_s, 1'b1);
        run(n, nwr);
        repeat (2) step();

        // Out-of-range on m1
        q1.push_back(mk(1, 12'd3750, 4'hF, 32'hDEAD_BEEF));
        drive();
        step();
        chk1("lit_oor_wr_cs", cs_s, 1'b0);
        q1.push_back(mk(0, 12'd3750, 4'hF, 0));
        drive();
        step();
        chk1("lit_oor_rd_cs", cs_s, 1'b0);
        @(negedge clk);
        chk1("lit_oor_rdv1", m1_if.readdatavalid, 1'b1);
        chk32("lit_oor_data", m1_if.readdata, 32'd0);
        chk1("lit_oor_rdv0", m0_if.readdatavalid, 1'b0);
`ifdef SISTEMA_RAM_ARB_ERRCNT_EN
        chk32("lit_oor_count", {16'd0, oor_count}, 32'd2);
        chk1("lit_oor_last", oor_last_master, 1'b1);
`endif

        // Last in-range word and one in-range read on m1
        @(posedge clk); #1;
        q1.push_back(mk(1, 12'd3749, 4'hF, 32'h0BAD_CAFE));
        q1.push_back(mk(0, 12'd3749, 4'hF, 0));
        drive();
        run(n, nwr);
        @(negedge clk);
        chk32("lit_last_word", m1_if.readdata, 32'h0BAD_CAFE);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
